// File: rtl/load_store_unit_if.sv
// Request/response handshake and word-memory port bundle for load_store_unit.
// slave: the unit itself; master: requester plus memory model.
interface load_store_unit_if #(
    parameter int unsigned ADDR_SIZE = 5
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic                   req_we_i;
    logic [1:0]             req_size_i;
    logic                   req_signed_i;
    logic [ADDR_SIZE+1:0]   req_addr_i;
    logic [31:0]            req_wdata_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic [31:0]            rsp_rdata_o;
    logic                   rsp_err_o;
    logic [ADDR_SIZE-1:0]   mem_addr_o;
    logic [31:0]            mem_data_o;
    logic                   mem_wen_o;
    logic [31:0]            mem_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i, mem_data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output mem_addr_o, mem_data_o, mem_wen_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
        output rsp_ready_i, mem_data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  mem_addr_o, mem_data_o, mem_wen_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a single-port word memory.
// Optional MISALIGN_TRAP_EN: misaligned or reserved-size requests return an error instead of aligning.
module load_store_unit #(
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    load_store_unit_if.slave  bus
);
    localparam int unsigned AW = ADDR_SIZE + 2;
    localparam int unsigned DW = WORD_SIZE;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]    state_q,  state_d;
    logic          we_q,     we_d;
    logic [1:0]    size_q,   size_d;
    logic          signed_q, signed_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [DW-1:0] wdata_q,  wdata_d;
    logic [DW-1:0] rdata_q,  rdata_d;
    logic          err_q,    err_d;
    logic [DW-1:0] wrdata_q, wrdata_d;
    logic          wen_q,    wen_d;
    logic          valid_q,  valid_d;
    logic          ready_q,  ready_d;

    logic [1:0]    size_eff_c;
    logic [AW-1:0] addr_eff_c;
    logic          err_c;

    // Request qualification: either trap on misalignment or force alignment
`ifdef MISALIGN_TRAP_EN
    always_comb begin
        size_eff_c = bus.req_size_i;
        addr_eff_c = bus.req_addr_i;
        err_c      = (bus.req_size_i == 2'b11)
                   || ((bus.req_size_i == SZ_HALF) && bus.req_addr_i[0])
                   || ((bus.req_size_i == SZ_WORD) && (bus.req_addr_i[1:0] != 2'b00));
    end
`else
    always_comb begin
        size_eff_c = (bus.req_size_i == 2'b11) ? SZ_WORD : bus.req_size_i;
        err_c      = 1'b0;
        case (size_eff_c)
            SZ_BYTE: addr_eff_c = bus.req_addr_i;
            SZ_HALF: addr_eff_c = {bus.req_addr_i[AW-1:1], 1'b0};
            default: addr_eff_c = {bus.req_addr_i[AW-1:2], 2'b00};
        endcase
    end
`endif

    logic [4:0]    sh_c;
    logic [DW-1:0] lane_c;
    logic [DW-1:0] load_c;
    logic [DW-1:0] mask_c;
    logic [DW-1:0] merge_c;

    // Lane extraction and read-modify-write merge, little-endian
    always_comb begin
        sh_c   = {addr_q[1:0], 3'b000};
        lane_c = bus.mem_data_i >> sh_c;
        case (size_q)
            SZ_BYTE: load_c = {{24{signed_q & lane_c[7]}},  lane_c[7:0]};
            SZ_HALF: load_c = {{16{signed_q & lane_c[15]}}, lane_c[15:0]};
            default: load_c = lane_c;
        endcase
        mask_c  = ((size_q == SZ_BYTE) ? DW'(32'h0000_00FF) : DW'(32'h0000_FFFF)) << sh_c;
        merge_c = (bus.mem_data_i & ~mask_c) | ((wdata_q << sh_c) & mask_c);
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        wrdata_d = wrdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    we_d     = bus.req_we_i;
                    size_d   = size_eff_c;
                    signed_d = bus.req_signed_i;
                    addr_d   = addr_eff_c;
                    wdata_d  = bus.req_wdata_i;
                    rdata_d  = '0;
                    err_d    = err_c;
                    if (err_c)                    state_d = S_RESP;
                    else if (!bus.req_we_i)       state_d = S_LOAD;
                    else if (size_eff_c == SZ_WORD) begin
                        wrdata_d = bus.req_wdata_i;
                        state_d  = S_WRITE;
                    end
                    else                          state_d = S_MERGE;
                end
            end
            S_LOAD: begin
                rdata_d = load_c;
                state_d = S_RESP;
            end
            S_MERGE: begin
                wrdata_d = merge_c;
                state_d  = S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (bus.rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs registered from the next state so they line up with it
        wen_d   = (state_d == S_WRITE);
        valid_d = (state_d == S_RESP);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wrdata_q <= '0;
            wen_q    <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            wrdata_q <= wrdata_d;
            wen_q    <= wen_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.req_ready_o = ready_q;
    assign bus.rsp_valid_o = valid_q;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.mem_addr_o  = addr_q[AW-1:2];
    assign bus.mem_data_o  = wrdata_q;
    assign bus.mem_wen_o   = wen_q;

    logic unused_we;
    assign unused_we = we_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized and directed requests checked
// against a byte-level memory model; MISALIGN_TRAP_EN selects the model's error rules.
module tb_load_store_unit;
    localparam int unsigned ADDR_SIZE = 5;
    localparam int unsigned NWORDS    = 1 << ADDR_SIZE;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_writes = 0;
    int   act_writes = 0;
    bit   hold_rsp = 1'b0;
    bit   in_resp = 1'b0;
    exp_t cur;
    exp_t expq[$];

    logic [31:0] tb_mem  [NWORDS];
    logic [31:0] ref_mem [NWORDS];

    load_store_unit_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

    load_store_unit #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_data_i = tb_mem[bus.mem_addr_o];
    always @(posedge clk) if (bus.mem_wen_o) tb_mem[bus.mem_addr_o] <= bus.mem_data_o;

    always @(posedge clk) begin
        #1;
        bus.rsp_ready_i = hold_rsp ? 1'b0 : ($urandom_range(0, 2) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed view of memory, one request at a time
    task automatic model(input bit we, input bit [1:0] size, input bit sgn, input bit [6:0] addr,
                         input bit [31:0] wdata, output bit [31:0] rd, output bit err,
                         output int lat, output bit wr);
        int n, a, off;
        bit mis;
        bit [31:0] w;
        bit [63:0] val;
        mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        rd = 0; err = 0; lat = 0; wr = 0;
        if (TRAP && mis) begin
            err = 1; lat = 1;
            return;
        end
        n   = (size == 2'd3) ? 4 : (1 << size);
        a   = int'(addr);
        a   = a - (a % n);
        off = a % 4;
        w   = ref_mem[a / 4];
        if (!we) begin
            val = (64'(w) >> (8 * off)) % (64'd1 << (8 * n));
            if (sgn && n < 4 && val >= (64'd1 << (8 * n - 1)))
                val = val + (64'd1 << 32) - (64'd1 << (8 * n));
            rd  = val[31:0];
            lat = 2;
        end else begin
            for (int i = 0; i < n; i++) w[8 * (off + i) +: 8] = wdata[8 * i +: 8];
            ref_mem[a / 4] = w;
            lat = (n == 4) ? 2 : 3;
            wr  = 1;
        end
    endtask

    task automatic issue(input bit we, input bit [1:0] size, input bit sgn, input bit [6:0] addr,
                         input bit [31:0] wdata, input bit push, input bit ovr, input bit [31:0] ovr_rd);
        int   waited;
        bit [31:0] rd;
        bit   err, wr;
        int   lat;
        exp_t e;
        @(negedge clk);
        bus.req_we_i     = we;
        bus.req_size_i   = size;
        bus.req_signed_i = sgn;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        bus.req_valid_i  = 1'b1;
        waited = 0;
        while (!bus.req_ready_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready_o) begin
            check("accept_timeout", 32'(bus.req_ready_o), 32'd1);
            bus.req_valid_i = 1'b0;
            return;
        end
        if (push) begin
            model(we, size, sgn, addr, wdata, rd, err, lat, wr);
            e.rd  = ovr ? ovr_rd : rd;
            e.err = err;
            e.lat = lat;
            e.acc = cyc;
            expq.push_back(e);
            if (wr) exp_writes++;
        end
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((expq.size() != 0 || in_resp) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (expq.size() != 0 || in_resp) check("drain_timeout", 32'(expq.size()), 32'd0);
    endtask

    // Monitor: pops one expectation per new response and checks it while held
    always @(negedge clk) begin
        if (rst) begin
            in_resp = 1'b0;
        end else begin
            if (bus.mem_wen_o) act_writes++;
            if (bus.rsp_valid_o) begin
                check("ready_in_resp", 32'(bus.req_ready_o), 32'd0);
                if (!in_resp) begin
                    if (expq.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        cur = expq.pop_front();
                        check("rsp_rdata", bus.rsp_rdata_o, cur.rd);
                        check("rsp_err", 32'(bus.rsp_err_o), 32'(cur.err));
                        check("rsp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
                        in_resp = 1'b1;
                    end
                end else begin
                    check("rsp_rdata_stable", bus.rsp_rdata_o, cur.rd);
                    check("rsp_err_stable", 32'(bus.rsp_err_o), 32'(cur.err));
                end
                if (bus.rsp_ready_i) in_resp = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] saved;
        int waited;
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_size_i   = 2'b00;
        bus.req_signed_i = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        bus.rsp_ready_i  = 1'b0;
        for (int i = 0; i < int'(NWORDS); i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[3]  = 32'h8081_82FF;
        ref_mem[3] = 32'h8081_82FF;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready_o), 32'd1);
        check("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rdata", bus.rsp_rdata_o, 32'd0);
        check("rst_err", 32'(bus.rsp_err_o), 32'd0);
        check("rst_wen", 32'(bus.mem_wen_o), 32'd0);
        rst = 1'b0;

        // Directed lane loads from word 3
        issue(1'b0, 2'd0, 1'b1, 7'h0C, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        issue(1'b0, 2'd0, 1'b0, 7'h0C, 32'h0, 1'b1, 1'b1, 32'h0000_00FF);
        issue(1'b0, 2'd1, 1'b1, 7'h0E, 32'h0, 1'b1, 1'b1, 32'hFFFF_8081);
        issue(1'b0, 2'd1, 1'b0, 7'h0E, 32'h0, 1'b1, 1'b1, 32'h0000_8081);
        issue(1'b0, 2'd2, 1'b1, 7'h0E, 32'h0, 1'b1, 1'b1, TRAP ? 32'h0 : 32'h8081_82FF);
        drain();

        issue(1'b1, 2'd0, 1'b0, 7'h0D, 32'hAB, 1'b1, 1'b0, 32'h0);
        drain();
        check("byte_store_mem", tb_mem[3], 32'h8081_ABFF);

        // Held response must stay stable with no acceptance
        hold_rsp = 1'b1;
        issue(1'b0, 2'd1, 1'b0, 7'h0E, 32'h0, 1'b1, 1'b1, 32'h0000_8081);
        waited = 0;
        while (!bus.rsp_valid_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("stall_rsp_seen", 32'(bus.rsp_valid_o), 32'd1);
        repeat (5) @(negedge clk);
        check("stall_valid_held", 32'(bus.rsp_valid_o), 32'd1);
        hold_rsp = 1'b0;
        drain();

        // Reset in MERGE aborts the store
        saved = tb_mem[3];
        issue(1'b1, 2'd0, 1'b0, 7'h0D, 32'h55, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_merge_wen", 32'(bus.mem_wen_o), 32'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_merge_wen_after", 32'(bus.mem_wen_o), 32'd0);
        end
        check("rst_merge_ready", 32'(bus.req_ready_o), 32'd1);
        check("rst_merge_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_merge_mem", tb_mem[3], saved);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            issue(1'($urandom), 2'($urandom), 1'($urandom), 7'($urandom), $urandom,
                  1'b1, 1'b0, 32'h0);
        end
        drain();

        for (int i = 0; i < int'(NWORDS); i++) check("final_mem", tb_mem[i], ref_mem[i]);
        check("write_count", 32'(act_writes), 32'(exp_writes));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have parameter ADDR_SIZE, default 5, giving the word-address width of the attached word memory.
REQ-002 The module SHALL have parameter WORD_SIZE, default 32, giving the data width; only 32 is supported.
REQ-003 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  input  1  request present.
REQ-006 req_ready_o  output  1  request accepted this cycle when high together with req_valid_i.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_size_i  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 req_signed_i  input  1  sign-extend load result (byte/halfword only).
REQ-010 req_addr_i  input  ADDR_SIZE+2  byte address.
REQ-011 req_wdata_i  input  32  store data, right-justified.
REQ-012 rsp_valid_o  output  1  response present.
REQ-013 rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-014 rsp_rdata_o  output  32  load result; 0 for stores.
REQ-015 rsp_err_o  output  1  misaligned or reserved-size request.
REQ-016 mem_addr_o  output  ADDR_SIZE  word address to memory.
REQ-017 mem_data_o  output  32  write data to memory.
REQ-018 mem_wen_o  output  1  memory write enable, sampled by memory on clk_i.
REQ-019 mem_data_i  input  32  asynchronous read data from memory at mem_addr_o.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, MERGE, WRITE, RESP; req_ready_o SHALL be high only in IDLE.
REQ-021 On acceptance the unit SHALL latch we, size, signed, address, wdata; mem_addr_o SHALL always equal latched address[ADDR_SIZE+1:2].
REQ-022 IDLE transitions on acceptance: error -> RESP; load -> LOAD; word store -> WRITE; byte/halfword store -> MERGE.
REQ-023 LOAD (one cycle) SHALL extract the addressed lane from mem_data_i (little-endian: byte offset 0 = bits 7:0), zero- or sign-extend per latched signed, register into rsp_rdata_o, -> RESP.
REQ-024 MERGE (one cycle) SHALL register mem_data_i with the addressed byte/halfword replaced by the low bits of wdata, -> WRITE.
REQ-025 WRITE (one cycle) SHALL drive mem_wen_o=1 and mem_data_o = wdata (word) or merged word, -> RESP; mem_wen_o SHALL be 0 in every other state.
REQ-026 RESP SHALL hold rsp_valid_o=1 and stable rsp_rdata_o/rsp_err_o until rsp_ready_i=1, then -> IDLE; no new request accepted in the same cycle.
REQ-027 Latency from acceptance to rsp_valid_o: load 2 cycles, word store 2, byte/halfword store 3, error 1.
REQ-028 Word signed flag SHALL be ignored; halfword offset 2 selects bits 31:16.

Reset
REQ-029 rst_i SHALL asynchronously force IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_wen_o=0, all latched fields 0.
REQ-030 Reset asserted in MERGE or WRITE SHALL abort the operation with no memory write on that or any later edge.

Configuration
REQ-031 With MISALIGN_TRAP_EN defined: halfword with addr[0]=1, word with addr[1:0]!=0, or size 11 SHALL set rsp_err_o=1, rsp_rdata_o=0, and perform no memory access.
REQ-032 Without MISALIGN_TRAP_EN: low address bits SHALL be cleared to the access alignment, size 11 treated as word, rsp_err_o tied 0.

Verification
REQ-033 Memory word 3 = 0x808182FF; byte load addr 0x0C signed -> rsp_rdata_o 0xFFFFFFFF 2 cycles after accept; unsigned -> 0x000000FF.
REQ-034 Halfword load addr 0x0E signed from same word -> 0xFFFF8081; unsigned -> 0x00008081.
REQ-035 Byte store 0xAB to addr 0x0D over 0x808182FF -> one mem_wen_o pulse with mem_data_o 0x8081ABFF, rsp_valid_o 3 cycles after accept.
REQ-036 Word load addr 0x0E: with MISALIGN_TRAP_EN -> rsp_err_o=1 after 1 cycle, mem_wen_o never high; without -> reads word 3, rsp_err_o=0.
REQ-037 Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o and data stable, req_ready_o=0 throughout.
REQ-038 Assert rst_i during MERGE of a byte store -> mem_wen_o stays 0, memory word unchanged, FSM in IDLE after release.
